// File: rtl/rv64_sequential_cpu.sv
// Single-cycle RV64 core (addi, add, sub, and, or, ld, sd, beq) with its own
// instruction memory, data memory and register file; one instruction per clock.

module rv64_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  // Contents are loaded from outside through hierarchy; the core only reads.
  logic [31:0] memory [0:DEPTH-1];
  assign data = memory[addr];
endmodule

module rv64_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          write_en,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   write_data,
  output logic [63:0]   read_data
);
  logic [63:0] memory [0:DEPTH-1];
  assign read_data = memory[addr];

  always_ff @(posedge clk) begin
    if (write_en) memory[addr] <= write_data;
  end
endmodule

module rv64_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        write_en,
  input  logic [63:0] write_data,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2
);
  logic [63:0] registers [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (write_en && rd != 5'd0) begin
      registers[rd] <= write_data;
    end
  end

  assign read_data1 = (rs1 == 5'd0) ? '0 : registers[rs1];
  assign read_data2 = (rs2 == 5'd0) ? '0 : registers[rs2];
endmodule

module rv64_sequential_cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  logic [63:0] pc_current, pc_next;
  logic [31:0] instruction;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        reg_write, mem_read, mem_write, branch, use_imm;
  alu_op_t     alu_op;
  logic [63:0] imm_i, imm_s, imm_b, imm;
  logic [63:0] reg_read_data1, reg_read_data2, alu_b, alu_result;
  logic [63:0] mem_read_data, reg_write_data;
  logic        unused_bits;

  rv64_imem #(.DEPTH(IMEM_DEPTH)) imem (
    .addr (pc_current[IA+1:2]),
    .data (instruction)
  );

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  // Anything outside the supported subset falls through with all controls low.
  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    use_imm   = 1'b1;
    imm       = imm_i;
    alu_op    = ALU_ADD;
    case (opcode)
      OP_IMM:   if (funct3 == 3'b000) reg_write = 1'b1;
      OP_REG: begin
        use_imm = 1'b0;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: reg_write = 1'b1;
          {7'b0100000, 3'b000}: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          {7'b0000000, 3'b111}: begin reg_write = 1'b1; alu_op = ALU_AND; end
          {7'b0000000, 3'b110}: begin reg_write = 1'b1; alu_op = ALU_OR;  end
          default: ;
        endcase
      end
      OP_LOAD: if (funct3 == 3'b011) begin reg_write = 1'b1; mem_read = 1'b1; end
      OP_STORE: begin
        imm = imm_s;
        if (funct3 == 3'b011) mem_write = 1'b1;
      end
      OP_BRANCH: begin
        use_imm = 1'b0;
        alu_op  = ALU_SUB;
        if (funct3 == 3'b000) branch = 1'b1;
      end
      default: ;
    endcase
  end

  rv64_reg_file reg_file (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_en   (reg_write),
    .write_data (reg_write_data),
    .read_data1 (reg_read_data1),
    .read_data2 (reg_read_data2)
  );

  assign alu_b = use_imm ? imm : reg_read_data2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = reg_read_data1 + alu_b;
      ALU_SUB: alu_result = reg_read_data1 - alu_b;
      ALU_AND: alu_result = reg_read_data1 & alu_b;
      ALU_OR:  alu_result = reg_read_data1 | alu_b;
      default: alu_result = '0;
    endcase
  end

  // Store is gated by reset so a held reset never disturbs data memory.
  rv64_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk        (clk),
    .write_en   (mem_write & reset),
    .addr       (alu_result[DA+2:3]),
    .write_data (reg_read_data2),
    .read_data  (mem_read_data)
  );

  assign reg_write_data = mem_read ? mem_read_data : alu_result;
  assign pc_next = (branch && alu_result == 64'd0) ? pc_current + imm_b : pc_current + 64'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_current <= '0;
    else        pc_current <= pc_next;
  end

  assign unused_bits = ^{pc_current[1:0], pc_current[63:IA+2],
                         alu_result[2:0], alu_result[63:DA+3]};
endmodule

// File: tb/tb_rv64_sequential_cpu.sv
// Bench for rv64_sequential_cpu: directed programs and a random program, all
// compared against an instruction-level model of the ISA subset.

module tb_rv64_sequential_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv64_sequential_cpu dut (.clk(clk), .reset(reset));

  int errors = 0;
  int checks = 0;
  int n_words = 0;

  logic [31:0] model_imem [0:255];
  logic [63:0] model_dmem [0:255];
  logic [63:0] model_regs [0:31];
  logic [63:0] model_pc;

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd,
                                        input logic [2:0] f3 = 3'b000,
                                        input logic [6:0] op = 7'h13);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b011, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_ld(input int imm, input int rs1, input int rd);
    return enc_i(imm, rs1, rd, 3'b011, 7'h03);
  endfunction

  function automatic void model_reset();
    model_pc = 64'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
  endfunction

  // Instruction-set level step: decode by mnemonic and apply its effect.
  function automatic void model_step();
    logic [31:0] inst;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [63:0] a, b, imm_i, imm_s, imm_b, addr, next_pc, result;
    logic        writes;
    inst   = model_imem[int'(model_pc >> 2) % 256];
    op     = inst[6:0];
    f3     = inst[14:12];
    f7     = inst[31:25];
    a      = model_regs[inst[19:15]];
    b      = model_regs[inst[24:20]];
    imm_i  = {{52{inst[31]}}, inst[31:20]};
    imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    next_pc = model_pc + 64'd4;
    writes = 1'b0;
    result = 64'd0;
    if (op == 7'h13 && f3 == 3'd0) begin writes = 1'b1; result = a + imm_i; end
    else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin writes = 1'b1; result = a + b; end
    else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin writes = 1'b1; result = a - b; end
    else if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) begin writes = 1'b1; result = a & b; end
    else if (op == 7'h33 && f3 == 3'd6 && f7 == 7'h00) begin writes = 1'b1; result = a | b; end
    else if (op == 7'h03 && f3 == 3'd3) begin
      addr = a + imm_i;
      writes = 1'b1;
      result = model_dmem[int'((addr >> 3) % 256)];
    end
    else if (op == 7'h23 && f3 == 3'd3) begin
      addr = a + imm_s;
      model_dmem[int'((addr >> 3) % 256)] = b;
    end
    else if (op == 7'h63 && f3 == 3'd0 && a == b) next_pc = model_pc + imm_b;
    if (writes && inst[11:7] != 5'd0) model_regs[inst[11:7]] = result;
    model_pc = next_pc;
  endfunction

  task automatic clear_program();
    for (int i = 0; i < 256; i++) model_imem[i] = 32'd0;
    n_words = 0;
  endtask

  task automatic emit(input logic [31:0] word);
    model_imem[n_words] = word;
    n_words++;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = model_imem[i];
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut.pc_current !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected 0", dut.pc_current);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.reg_file.registers[i] !== 64'd0) begin
        errors++;
        $display("[TB] FAIL reset_x%0d: got %h expected 0", i, dut.reg_file.registers[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [63:0] expected [1:6];
    expected = '{64'd10, 64'd11, 64'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd11};
    clear_program();
    emit(enc_i(10, 0, 1));
    emit(enc_i(11, 0, 2));
    emit(enc_r(7'h00, 2, 1, 3'b000, 3));
    emit(enc_r(7'h20, 2, 1, 3'b000, 4));
    emit(enc_r(7'h00, 2, 1, 3'b111, 5));
    emit(enc_r(7'h00, 2, 1, 3'b110, 6));
    load_program();
    restart();
    run_cycles(6);
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (dut.reg_file.registers[i] !== expected[i]) begin
        errors++;
        $display("[TB] FAIL arith_x%0d: got %h expected %h", i, dut.reg_file.registers[i], expected[i]);
      end
    end
    checks++;
    if (dut.pc_current !== 64'd24) begin
      errors++;
      $display("[TB] FAIL arith_pc: got %h expected 18", dut.pc_current);
    end
  endtask

  task automatic test_memory();
    clear_program();
    emit(enc_i(10, 0, 1));
    emit(enc_i(11, 0, 2));
    emit(enc_r(7'h00, 2, 1, 3'b000, 3));
    emit(enc_i(16, 0, 8));
    emit(enc_s(0, 3, 8));
    emit(enc_ld(0, 8, 7));
    load_program();
    restart();
    run_cycles(4);
    checks++;
    if ({dut.reg_write, dut.mem_read, dut.mem_write, dut.branch} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL sd_controls: got %b expected 0010",
               {dut.reg_write, dut.mem_read, dut.mem_write, dut.branch});
    end
    run_cycles(1);
    checks++;
    if (dut.dmem.memory[2] !== model_dmem[2] || model_dmem[2] !== 64'd21) begin
      errors++;
      $display("[TB] FAIL sd_data: got %h expected 15", dut.dmem.memory[2]);
    end
    checks++;
    if ({dut.reg_write, dut.mem_read, dut.mem_write, dut.branch} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL ld_controls: got %b expected 1100",
               {dut.reg_write, dut.mem_read, dut.mem_write, dut.branch});
    end
    run_cycles(1);
    checks++;
    if (dut.reg_file.registers[7] !== 64'd21) begin
      errors++;
      $display("[TB] FAIL ld_x7: got %h expected 15", dut.reg_file.registers[7]);
    end
  endtask

  task automatic test_branch();
    clear_program();
    emit(enc_i(10, 0, 1));
    emit(enc_i(11, 0, 2));
    emit(enc_b(8, 1, 2));
    emit(enc_i(5, 0, 1));
    emit(enc_i(5, 0, 2));
    emit(enc_i(1, 0, 9));
    emit(enc_i(0, 0, 0));
    emit(enc_i(0, 0, 0));
    emit(enc_b(8, 1, 2));
    emit(enc_i(99, 0, 10));
    emit(enc_i(7, 0, 11));
    load_program();
    restart();
    run_cycles(2);
    checks++;
    if (dut.branch !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beq_control: got %b expected 1", dut.branch);
    end
    run_cycles(1);
    checks++;
    if (dut.pc_current !== 64'd12) begin
      errors++;
      $display("[TB] FAIL beq_not_taken_pc: got %h expected c", dut.pc_current);
    end
    run_cycles(6);
    checks++;
    if (dut.pc_current !== 64'h28) begin
      errors++;
      $display("[TB] FAIL beq_taken_pc: got %h expected 28", dut.pc_current);
    end
    checks++;
    if (dut.reg_file.registers[10] !== 64'd0 || dut.reg_file.registers[9] !== 64'd1) begin
      errors++;
      $display("[TB] FAIL beq_skip: got x9=%h x10=%h expected x9=1 x10=0",
               dut.reg_file.registers[9], dut.reg_file.registers[10]);
    end
    run_cycles(1);
    checks++;
    if (dut.reg_file.registers[11] !== 64'd7 || dut.pc_current !== 64'h2c) begin
      errors++;
      $display("[TB] FAIL beq_target: got x11=%h pc=%h expected x11=7 pc=2c",
               dut.reg_file.registers[11], dut.pc_current);
    end
  endtask

  task automatic test_noop();
    clear_program();
    emit(enc_i(3, 0, 12));
    emit(enc_i(5, 0, 0));
    emit(32'h0000_0000);
    emit(enc_r(7'h00, 12, 12, 3'b001, 13));
    emit(enc_i(7, 12, 14, 3'b010));
    emit(enc_r(7'h01, 12, 12, 3'b000, 15));
    emit(enc_i(0, 12, 16, 3'b010, 7'h03));
    load_program();
    restart();
    run_cycles(1);
    for (int k = 1; k < 7; k++) begin
      if (k > 1) begin
        checks++;
        if ({dut.reg_write, dut.mem_read, dut.mem_write, dut.branch} !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL noop_controls_%0d: got %b expected 0000", k,
                   {dut.reg_write, dut.mem_read, dut.mem_write, dut.branch});
        end
      end
      run_cycles(1);
      checks++;
      if (dut.pc_current !== 64'(4 * (k + 1))) begin
        errors++;
        $display("[TB] FAIL noop_pc_%0d: got %h expected %h", k, dut.pc_current, 4 * (k + 1));
      end
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (dut.reg_file.registers[i] !== ((i == 12) ? 64'd3 : 64'd0)) begin
        errors++;
        $display("[TB] FAIL noop_x%0d: got %h", i, dut.reg_file.registers[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_program();
    emit(enc_s(0, 2, 1));
    emit(enc_i(40, 0, 1));
    emit(enc_i(-1, 0, 2));
    emit(enc_s(0, 2, 1));
    emit(enc_i(3, 0, 3));
    load_program();
    restart();
    run_cycles(5);
    dut.dmem.memory[0] = 64'h1234;
    model_dmem[0] = 64'h1234;
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut.pc_current !== 64'd0) begin
      errors++;
      $display("[TB] FAIL midreset_pc: got %h expected 0", dut.pc_current);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (dut.reg_file.registers[i] !== 64'd0) begin
        errors++;
        $display("[TB] FAIL midreset_x%0d: got %h expected 0", i, dut.reg_file.registers[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.dmem.memory[0] !== 64'h1234 || dut.dmem.memory[5] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL midreset_dmem: got [0]=%h [5]=%h expected 1234 and all ones",
               dut.dmem.memory[0], dut.dmem.memory[5]);
    end
    reset = 1'b1;
    run_cycles(1);
    checks++;
    if (dut.pc_current !== 64'd4 || dut.dmem.memory[0] !== model_dmem[0]) begin
      errors++;
      $display("[TB] FAIL midreset_resume: got pc=%h [0]=%h expected pc=4 [0]=%h",
               dut.pc_current, dut.dmem.memory[0], model_dmem[0]);
    end
  endtask

  task automatic test_random();
    int kind, imm;
    clear_program();
    for (int r = 1; r < 8; r++) emit(enc_i(int'($urandom_range(0, 4095)) - 2048, 0, r));
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 8));
      imm  = int'($urandom_range(0, 4095)) - 2048;
      case (kind)
        0: emit(enc_i(imm, $urandom_range(0, 7), $urandom_range(0, 7)));
        1: emit(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 3'b000, $urandom_range(0, 7)));
        2: emit(enc_r(7'h20, $urandom_range(0, 7), $urandom_range(0, 7), 3'b000, $urandom_range(0, 7)));
        3: emit(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 3'b111, $urandom_range(0, 7)));
        4: emit(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 3'b110, $urandom_range(0, 7)));
        5: emit(enc_ld(imm, $urandom_range(0, 7), $urandom_range(0, 7)));
        6: emit(enc_s(imm, $urandom_range(0, 7), $urandom_range(0, 7)));
        7: begin
          imm = (int'($urandom_range(0, 7)) - 3) * 4;
          if (imm == 0) imm = 8;
          emit(enc_b(imm, $urandom_range(0, 7), $urandom_range(0, 7)));
        end
        default: emit($urandom);
      endcase
    end
    load_program();
    restart();
    for (int c = 0; c < 60; c++) begin
      run_cycles(1);
      checks++;
      if (dut.pc_current !== model_pc) begin
        errors++;
        $display("[TB] FAIL random_pc_cycle%0d: got %h expected %h", c, dut.pc_current, model_pc);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.reg_file.registers[i] !== model_regs[i]) begin
        errors++;
        $display("[TB] FAIL random_x%0d: got %h expected %h", i, dut.reg_file.registers[i], model_regs[i]);
      end
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (dut.dmem.memory[i] !== model_dmem[i]) begin
        errors++;
        $display("[TB] FAIL random_dmem%0d: got %h expected %h", i, dut.dmem.memory[i], model_dmem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_dmem[i] = 64'd0;
      dut.dmem.memory[i] = 64'd0;
    end
    clear_program();
    load_program();
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_noop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
